// File: rtl/bb_slave_port.sv
// bb_slave_port: responder end of the serial bit bus.
// Receives a 16-bit address MSB-first, claims it when the upper nibble
// matches SLAVE_ID, then either writes one byte to the local memory or
// fetches one byte and returns it MSB-first, holding the master with
// split while the memory is busy.
module bb_slave_port #(
    parameter logic [3:0] SLAVE_ID   = 4'h1,
    parameter int         ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    output logic                  slave_ready,
    output logic                  ack,
    input  logic                  master_ready,
    output logic                  slave_valid,
    output logic                  rd_bus,
    output logic                  split,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_rvalid
);

    typedef enum logic [2:0] {
        IDLE, ADDR, IGNORE, WDATA, WRITE, RD_REQ, RD_WAIT, RDATA
    } state_t;

    // The address window only needs to hold the ID nibble early on and the
    // low ADDR_WIDTH bits at the end; older bits simply shift out the top.
    localparam int SR_W = (ADDR_WIDTH > 4) ? ADDR_WIDTH : 4;

    state_t          state, state_nx;
    logic [SR_W-2:0] addr_sr;
    logic [SR_W-1:0] addr_nx;
    logic [3:0]      bit_cnt;
    logic            sel;
    logic [7:0]      wdata_sr;
    logic [7:0]      rdata_sr;

    assign addr_nx = {addr_sr, wr_bus};

    // State register; reset forces IDLE so every decoded output drops at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and output decode.
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_nx    = state;
        slave_ready = 1'b0;
        ack         = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        split       = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = 8'h00;
        case (state)
            IDLE: begin
                slave_ready = master_valid;
                if (master_valid) state_nx = ADDR;
            end
            ADDR: begin
                slave_ready = master_valid;
                ack         = master_valid && sel && (bit_cnt == 4'd4 || bit_cnt == 4'd5);
                if (!master_valid)                  state_nx = IDLE;
                else if (bit_cnt == 4'd5 && !sel)   state_nx = IGNORE;
                else if (bit_cnt == 4'd15)          state_nx = mode ? WDATA : RD_REQ;
            end
            IGNORE: begin
                if (!master_valid && !master_ready) state_nx = IDLE;
            end
            WDATA: begin
                slave_ready = master_valid;
                if (!master_valid)          state_nx = IDLE;
                else if (bit_cnt == 4'd7)   state_nx = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = wdata_sr;
                state_nx  = IDLE;
            end
            RD_REQ: begin
                mem_re   = 1'b1;
                split    = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                split = 1'b1;
                if (mem_rvalid) state_nx = RDATA;
            end
            RDATA: begin
                slave_valid = master_ready;
                rd_bus      = rdata_sr[7];
                if (master_ready && bit_cnt == 4'd7) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The state is already IDLE during reset, but IDLE readiness follows
        // master_valid combinationally, so hold it low explicitly.
        if (!rstn) slave_ready = 1'b0;
    end

    // Capture datapath: address/data shifting, ID match, read byte shift-out.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_sr  <= '0;
            bit_cnt  <= 4'd0;
            sel      <= 1'b0;
            wdata_sr <= 8'h00;
            rdata_sr <= 8'h00;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: if (master_valid) begin
                    addr_sr <= addr_nx[SR_W-2:0];
                    bit_cnt <= 4'd1;
                    sel     <= 1'b0;
                end
                ADDR: if (master_valid) begin
                    addr_sr <= addr_nx[SR_W-2:0];
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd3) sel <= (addr_nx[3:0] == SLAVE_ID);
                    if (bit_cnt == 4'd15) begin
                        mem_addr <= addr_nx[ADDR_WIDTH-1:0];
                        bit_cnt  <= 4'd0;
                    end
                end
                WDATA: if (master_valid) begin
                    wdata_sr <= {wdata_sr[6:0], wr_bus};
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                RD_WAIT: if (mem_rvalid) begin
                    rdata_sr <= mem_rdata;
                    bit_cnt  <= 4'd0;
                end
                RDATA: if (master_ready) begin
                    rdata_sr <= {rdata_sr[6:0], 1'b0};
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
